// File: rtl/ysyx_23060111_lsu.sv
// Load/store unit: one request at a time from execute, bridged onto split AXI-lite style
// read and write channels, with a one-cycle completion pulse back to the pipeline.
module ysyx_23060111_lsu (
    input  logic        clk,
    input  logic        rst,
    // request from execute
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_wen,
    input  logic        in_ren,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_mask,
    // completion
    output logic        out_valid,
    output logic [31:0] out_rdata,
    output logic        out_err,
    // read channels
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    // write channels
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_mask;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_direct;
    logic [31:0] w_rshift;
    logic [31:0] w_rd_ext;
    logic [31:0] w_rdata_d;
    logic        w_err_d;

    assign w_accept = in_valid && (r_state == IDLE);

    always_comb begin
        w_misaligned = 1'b0;
        if (in_mask == 32'd1) begin
            w_misaligned = 1'b0;
        end else if (in_mask == 32'd2) begin
            w_misaligned = in_addr[0];
        end else if (in_mask == 32'd4) begin
            w_misaligned = (in_addr[1:0] != 2'b00);
        end else begin
            w_misaligned = 1'b1;
        end
    end

    // No-ops and misaligned accesses complete without touching the bus.
    assign w_direct = !(in_wen || in_ren) || w_misaligned;

    assign w_rshift = rdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_mask)
            3'd1:    w_rd_ext = {24'd0, w_rshift[7:0]};
            3'd2:    w_rd_ext = {16'd0, w_rshift[15:0]};
            default: w_rd_ext = w_rshift;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_direct) begin
                        w_state_d = DONE;
                        w_rdata_d = 32'd0;
                        w_err_d   = w_misaligned && (in_wen || in_ren);
                    end else if (in_wen) begin
                        w_state_d = WR_REQ;
                    end else begin
                        w_state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready) w_state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid) begin
                    w_state_d = DONE;
                    w_rdata_d = w_rd_ext;
                    w_err_d   = (rresp != 2'b00);
                end
            end
            WR_REQ: begin
                // Each channel's handshake is either already recorded or happening now.
                if ((r_aw_done || awready) && (r_w_done || wready)) w_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid) begin
                    w_state_d = DONE;
                    w_rdata_d = 32'd0;
                    w_err_d   = (bresp != 2'b00);
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_mask    <= 3'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
            if (w_accept) begin
                r_addr    <= in_addr;
                r_wdata   <= in_wdata;
                r_mask    <= in_mask[2:0];
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == WR_REQ) begin
                if (awready) r_aw_done <= 1'b1;
                if (wready)  r_w_done  <= 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_rdata = r_rdata;
    assign out_err   = r_err;

    assign arvalid = (r_state == RD_ADDR);
    assign rready  = (r_state == RD_DATA);
    assign awvalid = (r_state == WR_REQ) && !r_aw_done;
    assign wvalid  = (r_state == WR_REQ) && !r_w_done;
    assign bready  = (r_state == WR_RESP);

    assign araddr = {r_addr[31:2], 2'b00};
    assign awaddr = {r_addr[31:2], 2'b00};
    assign wdata  = r_wdata << {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_mask)
            3'd1:    wstrb = 4'b0001 << r_addr[1:0];
            3'd2:    wstrb = 4'b0011 << r_addr[1:0];
            3'd4:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060111_lsu.sv
// Bench for ysyx_23060111_lsu: vector table against a zero-wait slave, plus hand-driven
// split-handshake and reset-abandon sequences; completions are checked from a scoreboard.
module tb_ysyx_23060111_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wen;
    logic        in_ren;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] in_mask;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    ysyx_23060111_lsu u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_wen    (in_wen),
        .in_ren    (in_ren),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_rdata (out_rdata),
        .out_err   (out_err),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    // kind: 0 = completes without bus traffic, 1 = read, 2 = write
    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] mask;
        logic [31:0] rdat;
        logic [1:0]  resp;
        int          kind;
        logic [31:0] exp_baddr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic slave_idle();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'd0;
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_rdata", out_rdata, e.rdata);
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        bit seen_ar, seen_aw, seen_w, got;
        seen_ar = 0; seen_aw = 0; seen_w = 0; got = 0;
        @(negedge clk);
        check($sformatf("in_ready_v%0d", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_wen = v.wen; in_ren = v.ren;
        in_addr = v.addr; in_wdata = v.wdat; in_mask = v.mask;
        arready = 1'b1; rvalid = 1'b1; rdata = v.rdat; rresp = v.resp;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = v.resp;
        sb_q.push_back('{v.exp_rdata, v.exp_err});
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (k <= 20 && !got) begin
            if (arvalid && !seen_ar) begin
                seen_ar = 1;
                check($sformatf("araddr_v%0d", idx), araddr, v.exp_baddr);
            end
            if (awvalid && !seen_aw) begin
                seen_aw = 1;
                check($sformatf("awaddr_v%0d", idx), awaddr, v.exp_baddr);
            end
            if (wvalid && !seen_w) begin
                seen_w = 1;
                check($sformatf("wdata_v%0d", idx), wdata, v.exp_wdata);
                check($sformatf("wstrb_v%0d", idx), 32'(wstrb), 32'(v.exp_wstrb));
            end
            if (out_valid) got = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("completed_v%0d", idx), 32'(got), 32'd1);
        if (got) check($sformatf("latency_v%0d", idx), k, (v.kind == 0) ? 32'd1 : 32'd3);
        check($sformatf("ar_seen_v%0d", idx), 32'(seen_ar), 32'(v.kind == 1));
        check($sformatf("aw_seen_v%0d", idx), 32'(seen_aw), 32'(v.kind == 2));
        slave_idle();
        @(negedge clk);
        check($sformatf("pulse_one_cycle_v%0d", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wen ren addr          wdata         mask  rdata         rsp kind baddr         exp_rdata     err exp_wdata     strb
        vecs[0]  = '{0, 1, 32'h8000_0003, 32'h0,        32'd1, 32'hAABB_CCDD, 0, 1, 32'h8000_0000, 32'h0000_00AA, 0, 32'h0,        4'h0};
        vecs[1]  = '{0, 1, 32'h8000_0002, 32'h0,        32'd2, 32'hAABB_CCDD, 0, 1, 32'h8000_0000, 32'h0000_AABB, 0, 32'h0,        4'h0};
        vecs[2]  = '{0, 1, 32'h8000_0004, 32'h0,        32'd4, 32'h1234_5678, 0, 1, 32'h8000_0004, 32'h1234_5678, 0, 32'h0,        4'h0};
        vecs[3]  = '{0, 1, 32'h8000_0001, 32'h0,        32'd1, 32'hAABB_CCDD, 0, 1, 32'h8000_0000, 32'h0000_00CC, 0, 32'h0,        4'h0};
        vecs[4]  = '{0, 1, 32'h8000_0000, 32'h0,        32'd4, 32'hDEAD_BEEF, 2, 1, 32'h8000_0000, 32'hDEAD_BEEF, 1, 32'h0,        4'h0};
        vecs[5]  = '{0, 1, 32'h8000_0008, 32'h0,        32'd1, 32'h1122_3344, 0, 1, 32'h8000_0008, 32'h0000_0044, 0, 32'h0,        4'h0};
        vecs[6]  = '{0, 1, 32'h8000_0001, 32'h0,        32'd4, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0,         1, 32'h0,        4'h0};
        vecs[7]  = '{0, 1, 32'h8000_000C, 32'h0,        32'd4, 32'h0BAD_F00D, 0, 1, 32'h8000_000C, 32'h0BAD_F00D, 0, 32'h0,        4'h0};
        vecs[8]  = '{0, 0, 32'h8000_0000, 32'h0,        32'd4, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0,         0, 32'h0,        4'h0};
        vecs[9]  = '{1, 0, 32'h8000_0102, 32'h1234_5678, 32'd2, 32'h0,        0, 2, 32'h8000_0100, 32'h0,         0, 32'h5678_0000, 4'hC};
        vecs[10] = '{1, 0, 32'h8000_0001, 32'h0000_00AB, 32'd1, 32'h0,        0, 2, 32'h8000_0000, 32'h0,         0, 32'h0000_AB00, 4'h2};
        vecs[11] = '{1, 0, 32'h8000_0010, 32'hCAFE_BABE, 32'd4, 32'h0,        0, 2, 32'h8000_0010, 32'h0,         0, 32'hCAFE_BABE, 4'hF};
        vecs[12] = '{1, 0, 32'h8000_0014, 32'h0000_0001, 32'd4, 32'h0,        3, 2, 32'h8000_0014, 32'h0,         1, 32'h0000_0001, 4'hF};
        vecs[13] = '{1, 1, 32'h8000_0023, 32'h0000_00EE, 32'd1, 32'hFFFF_FFFF, 0, 2, 32'h8000_0020, 32'h0,         0, 32'hEE00_0000, 4'h8};
        vecs[14] = '{1, 0, 32'h8000_0000, 32'h1111_1111, 32'd3, 32'h0,        0, 0, 32'h0,         32'h0,         1, 32'h0,        4'h0};
        vecs[15] = '{0, 1, 32'h8000_0003, 32'h0,        32'd2, 32'hFFFF_FFFF, 0, 0, 32'h0,         32'h0,         1, 32'h0,        4'h0};

        in_valid = 1'b0; in_wen = 1'b0; in_ren = 1'b0;
        in_addr = 32'd0; in_wdata = 32'd0; in_mask = 32'd0;
        slave_idle();
        rst = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_rready", 32'(rready), 32'd0);
        check("rst_awvalid", 32'(awvalid), 32'd0);
        check("rst_wvalid", 32'(wvalid), 32'd0);
        check("rst_bready", 32'(bready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_rdata", out_rdata, 32'd0);
        check("rst_araddr", araddr, 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_wstrb", 32'(wstrb), 32'd0);
        rst = 1'b0;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Split write handshakes; in_valid held high meanwhile must not queue a request.
        @(negedge clk);
        in_valid = 1'b1; in_wen = 1'b1; in_ren = 1'b0;
        in_addr = 32'h8000_0040; in_wdata = 32'h0102_0304; in_mask = 32'd4;
        sb_q.push_back('{32'h0, 1'b0});
        @(negedge clk);
        in_wen = 1'b0; in_ren = 1'b1; in_addr = 32'h8000_0080;
        check("split_awvalid_0", 32'(awvalid), 32'd1);
        check("split_wvalid_0", 32'(wvalid), 32'd1);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        check("split_wvalid_drop", 32'(wvalid), 32'd0);
        check("split_awvalid_hold", 32'(awvalid), 32'd1);
        check("split_bready_early", 32'(bready), 32'd0);
        @(negedge clk);
        check("split_awvalid_hold2", 32'(awvalid), 32'd1);
        check("split_bready_early2", 32'(bready), 32'd0);
        check("split_awaddr", awaddr, 32'h8000_0040);
        in_valid = 1'b0;
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("split_awvalid_drop", 32'(awvalid), 32'd0);
        check("split_bready", 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = 2'd0;
        @(negedge clk);
        bvalid = 1'b0;
        check("split_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("split_single_done", 32'(out_valid), 32'd0);
        check("split_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);

        // Reset while waiting in RD_DATA.
        in_valid = 1'b1; in_wen = 1'b0; in_ren = 1'b1;
        in_addr = 32'h8000_0000; in_mask = 32'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check("rr_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("rr_rready", 32'(rready), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rr_rready_drop", 32'(rready), 32'd0);
        check("rr_out_valid", 32'(out_valid), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd1);
        check("rr_out_rdata", out_rdata, 32'd0);
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rr_late_rvalid_%0d", i), 32'(out_valid), 32'd0);
        end
        slave_idle();

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060111_lsu.md
YSYX_23060111_LSU -- requirements
Module: ysyx_23060111_LSU

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 The module SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-003 The request side from the execute stage SHALL have these ports: in_valid input 1; in_ready output 1; in_wen input 1; in_ren input 1; in_addr input 32; in_wdata input 32; in_mask input 32, access size in bytes (1, 2 or 4).
REQ-004 The response side SHALL have these ports: out_valid output 1, one-cycle completion pulse; out_rdata output 32, right-aligned, zero-filled load data; out_err output 1, error flag.
REQ-005 The read channels SHALL be: araddr output 32; arvalid output 1; arready input 1; rdata input 32; rresp input 2; rvalid input 1; rready output 1.
REQ-006 The write channels SHALL be: awaddr output 32; awvalid output 1; awready input 1; wdata output 32; wstrb output 4; wvalid output 1; wready input 1; bresp input 2; bvalid input 1; bready output 1.

Function
REQ-007 The FSM SHALL have exactly these states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-008 in_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on the edge where in_valid && in_ready; address, data, mask and direction are latched at acceptance.
REQ-009 If in_wen=1 at acceptance, the request SHALL be a write, even when in_ren=1; otherwise, if in_ren=1, it SHALL be a read.
REQ-010 If in_wen=0 and in_ren=0 at acceptance, the FSM SHALL go directly to DONE with out_err=0, out_rdata=0 and no bus traffic.
REQ-011 A request SHALL be misaligned when in_mask is not in {1,2,4}, or mask=2 with addr[0]=1, or mask=4 with addr[1:0]≠0.
REQ-012 A misaligned read or write SHALL go directly to DONE with out_err=1, out_rdata=0 and no bus traffic.
REQ-013 araddr and awaddr SHALL equal {addr[31:2],2'b00}.
REQ-014 wdata SHALL be wdata_latched << (8*addr[1:0]).
REQ-015 wstrb SHALL be 4'b0001<<addr[1:0] for mask 1, 4'b0011<<addr[1:0] for mask 2, and 4'b1111 for mask 4.
REQ-016 Read: from IDLE the FSM SHALL go to RD_ADDR with arvalid=1, holding arvalid and araddr stable until arready=1.
REQ-017 On the arvalid&&arready edge, the FSM SHALL enter RD_DATA, drop arvalid, and raise rready.
REQ-018 On the rvalid&&rready edge, the FSM SHALL capture out_rdata = (rdata >> 8*addr[1:0]), masked to 8, 16 or 32 bits per size, and capture out_err = (rresp≠0), then enter DONE.
REQ-019 Write: from IDLE the FSM SHALL go to WR_REQ with awvalid=1 and wvalid=1 together.
REQ-020 In WR_REQ, each of awvalid and wvalid SHALL deassert independently on its own handshake edge, and the FSM SHALL enter WR_RESP with bready=1 once both handshakes have completed, including when both complete on the same edge.
REQ-021 On the bvalid&&bready edge, the FSM SHALL capture out_err = (bresp≠0), set out_rdata=0, and enter DONE.
REQ-022 In DONE, out_valid SHALL be 1 for exactly one cycle; the FSM then returns to IDLE, and out_rdata and out_err hold until the next completion.
REQ-023 Every valid/ready output SHALL be a registered state-derived signal, SHALL not depend combinationally on any bus input, and SHALL never drop before its handshake.
REQ-024 The minimum read latency SHALL be 3 cycles: accept at edge t, arvalid during t..t+1, rready during t+1..t+2, out_valid during t+2..t+3 when arready and rvalid are 1 immediately.
REQ-025 The minimum write latency SHALL also be 3 cycles.
REQ-026 in_valid asserted outside IDLE SHALL be ignored and SHALL not be queued.

Reset
REQ-027 When rst=1 at a clock edge, state SHALL become IDLE, and arvalid, rready, awvalid, wvalid, bready, out_valid and out_err SHALL be 0, out_rdata SHALL be 0x0000_0000, and araddr, awaddr, wdata and wstrb SHALL be 0.
REQ-028 A reset during any non-IDLE state SHALL abandon the transaction: all valid/ready outputs drop at that edge, no out_valid is produced, and late bus responses are ignored.
REQ-029 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-030 A bench SHALL cover a read byte: in_ren=1, addr=0x8000_0003, mask=1, rdata=0xAABB_CCDD, rresp=0, zero-wait slave -> araddr=0x8000_0000, out_rdata=0x0000_00AA, out_err=0, out_valid 3 cycles after accept.
REQ-031 A bench SHALL cover a halfword store: in_wen=1, addr=0x8000_0102, mask=2, wdata=0x1234_5678 -> awaddr=0x8000_0100, wdata=0x5678_0000, wstrb=4'b1100, out_valid after bvalid, out_err=0.
REQ-032 A bench SHALL cover split write handshakes: wready asserted 2 cycles before awready -> wvalid drops first, awvalid stays high, and bready asserts only after awready, with a single completion.
REQ-033 A bench SHALL cover a misaligned request: in_ren=1, addr=0x8000_0001, mask=4 -> no arvalid, out_valid next cycle with out_err=1 and out_rdata=0.
REQ-034 A bench SHALL cover a slave error: a read with rresp=2'b10 -> out_err=1; a following good read -> out_err=0.
REQ-035 A bench SHALL cover reset mid-read: rst=1 while in RD_DATA with rvalid held at 0 -> rready=0 next cycle, no out_valid, in_ready=1 after rst release, and a later rvalid causes no response.
